// File: rtl/pio_pkg.sv
// ============================================================================
// Package : pio_pkg
// Brief   : Shared constants and helpers for the fifo_pair block: join-mode
//           encodings, sticky status bit positions and a capacity function.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package pio_pkg;

    // Join-mode encodings carried on the join_mode input
    localparam logic [1:0] JOIN_NONE = 2'b00;
    localparam logic [1:0] JOIN_TX   = 2'b01;
    localparam logic [1:0] JOIN_RX   = 2'b10;

    // Bit positions inside the sticky status vector
    localparam int STAT_TX_OVER  = 0;
    localparam int STAT_TX_UNDER = 1;
    localparam int STAT_RX_OVER  = 2;
    localparam int STAT_RX_UNDER = 3;

    // Encoding 11 behaves exactly like "no join"
    function automatic logic [1:0] norm_join(input logic [1:0] mode);
        return (mode == 2'b11) ? JOIN_NONE : mode;
    endfunction

    // Words available to one direction for a given (normalised) join mode
    function automatic int unsigned fifo_capacity(input logic [1:0]  mode,
                                                  input logic        is_rx,
                                                  input int unsigned depth);
        int unsigned cap;
        cap = depth;
        if (mode == JOIN_TX) begin
            cap = is_rx ? 0 : 2 * depth;
        end else if (mode == JOIN_RX) begin
            cap = is_rx ? 2 * depth : 0;
        end
        return cap;
    endfunction

endpackage : pio_pkg

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Control half of a first-word-fall-through FIFO with a runtime
//          capacity (0..MAX_DEPTH). Storage lives outside; this block drives
//          relative write/read addresses and masks the head word when empty.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter  int WIDTH     = 32,
    parameter  int MAX_DEPTH = 8,
    localparam int PW        = $clog2(MAX_DEPTH),
    localparam int LW        = $clog2(MAX_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [LW-1:0]    capacity,
    input  logic             write,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level,
    output logic             over,
    output logic             under,
    output logic             mem_we,
    output logic [PW-1:0]    mem_waddr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [PW-1:0]    mem_raddr,
    input  logic [WIDTH-1:0] mem_rdata
);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;

    logic          w_pop_ok;
    logic          w_wr_ok;
    logic          w_active;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;

    // Flags come straight from the registered level
    assign empty = (r_level == '0);
    assign full  = (r_level == capacity);
    assign level = r_level;

    // A flush cycle ignores traffic entirely, including error reporting
    assign w_active = !reset && !flush;
    assign w_pop_ok = w_active && pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_wr_ok  = w_active && write && (!full || w_pop_ok);
    assign over     = w_active && write && !w_wr_ok;
    assign under    = w_active && pop && empty;

    // Pointer advance wraps at the current capacity, not the physical size
    always_comb begin
        w_wptr_nxt = r_wptr + PW'(1);
        w_rptr_nxt = r_rptr + PW'(1);
        if (({1'b0, r_wptr} + LW'(1)) == capacity) begin
            w_wptr_nxt = '0;
        end
        if (({1'b0, r_rptr} + LW'(1)) == capacity) begin
            w_rptr_nxt = '0;
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_pop_ok) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_wr_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign mem_we    = w_wr_ok;
    assign mem_waddr = r_wptr;
    assign mem_wdata = wdata;
    assign mem_raddr = r_rptr;
    assign dout      = empty ? '0 : mem_rdata;

endmodule : sync_fifo

`default_nettype wire

// File: rtl/fifo_pair.sv
// ============================================================================
// Module : fifo_pair
// Brief  : Host<->machine FIFO pair (TX toward the machine, RX back to the
//          host) over one 2*DEPTH-word storage array, with sticky over/under
//          status flags and write-one-to-clear.
// Config : FIFO_PAIR_JOIN_EN - when defined, join_mode can give all storage
//          to TX (01) or RX (10); a mode change flushes both FIFOs. When
//          undefined, join_mode is ignored and each side holds DEPTH words.
// Note   : the join select port is called join_mode because "join" is a
//          reserved word in SystemVerilog.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_pair
    import pio_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 join_mode,
    input  logic                       tx_write,
    input  logic [WIDTH-1:0]           tx_wdata,
    input  logic                       tx_pull,
    output logic [WIDTH-1:0]           tx_dout,
    output logic                       tx_empty,
    output logic                       tx_full,
    input  logic                       rx_push,
    input  logic [WIDTH-1:0]           rx_din,
    input  logic                       rx_read,
    output logic [WIDTH-1:0]           rx_rdata,
    output logic                       rx_empty,
    output logic                       rx_full,
    output logic [$clog2(2*DEPTH):0]   tx_level,
    output logic [$clog2(2*DEPTH):0]   rx_level,
    output logic [3:0]                 status,
    input  logic [3:0]                 status_clr
);

    localparam int MAX_DEPTH = 2 * DEPTH;
    localparam int PW        = $clog2(MAX_DEPTH);
    localparam int LW        = $clog2(MAX_DEPTH) + 1;

    logic [1:0]       w_mode;
    logic             w_flush;
    logic [LW-1:0]    w_tx_cap;
    logic [LW-1:0]    w_rx_cap;
    logic [PW-1:0]    w_rx_base;

    logic [WIDTH-1:0] r_mem [MAX_DEPTH];

    logic             w_tx_we;
    logic [PW-1:0]    w_tx_waddr;
    logic [WIDTH-1:0] w_tx_wdata;
    logic [PW-1:0]    w_tx_raddr;
    logic [WIDTH-1:0] w_tx_rdata;
    logic             w_tx_over;
    logic             w_tx_under;

    logic             w_rx_we;
    logic [PW-1:0]    w_rx_waddr;
    logic [WIDTH-1:0] w_rx_wdata;
    logic [PW-1:0]    w_rx_raddr;
    logic [WIDTH-1:0] w_rx_rdata;
    logic             w_rx_over;
    logic             w_rx_under;

    logic [3:0]       r_status;
    logic [3:0]       w_status_set;

`ifdef FIFO_PAIR_JOIN_EN
    logic [1:0] w_join_eff;
    logic [1:0] r_join;

    assign w_join_eff = norm_join(join_mode);

    // Remember the mode in force; reset simply adopts the current select
    always_ff @(posedge clk) begin
        r_join <= w_join_eff;
    end

    // Capacities follow the registered mode so full/empty stay state-derived
    assign w_mode  = r_join;
    assign w_flush = !reset && (w_join_eff != r_join);
`else
    logic w_unused_join;

    assign w_unused_join = ^join_mode;
    assign w_mode        = JOIN_NONE;
    assign w_flush       = 1'b0;
`endif

    assign w_tx_cap  = LW'(fifo_capacity(w_mode, 1'b0, DEPTH));
    assign w_rx_cap  = LW'(fifo_capacity(w_mode, 1'b1, DEPTH));
    // TX always starts at word 0; RX sits above TX unless it owns everything
    assign w_rx_base = (w_mode == JOIN_RX) ? '0 : PW'(DEPTH);

    sync_fifo #(
        .WIDTH     (WIDTH),
        .MAX_DEPTH (MAX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_flush),
        .capacity  (w_tx_cap),
        .write     (tx_write),
        .wdata     (tx_wdata),
        .pop       (tx_pull),
        .dout      (tx_dout),
        .empty     (tx_empty),
        .full      (tx_full),
        .level     (tx_level),
        .over      (w_tx_over),
        .under     (w_tx_under),
        .mem_we    (w_tx_we),
        .mem_waddr (w_tx_waddr),
        .mem_wdata (w_tx_wdata),
        .mem_raddr (w_tx_raddr),
        .mem_rdata (w_tx_rdata)
    );

    sync_fifo #(
        .WIDTH     (WIDTH),
        .MAX_DEPTH (MAX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_flush),
        .capacity  (w_rx_cap),
        .write     (rx_push),
        .wdata     (rx_din),
        .pop       (rx_read),
        .dout      (rx_rdata),
        .empty     (rx_empty),
        .full      (rx_full),
        .level     (rx_level),
        .over      (w_rx_over),
        .under     (w_rx_under),
        .mem_we    (w_rx_we),
        .mem_waddr (w_rx_waddr),
        .mem_wdata (w_rx_wdata),
        .mem_raddr (w_rx_raddr),
        .mem_rdata (w_rx_rdata)
    );

    // Shared storage; the two regions never overlap so both ports can write
    always_ff @(posedge clk) begin
        if (w_tx_we) begin
            r_mem[w_tx_waddr] <= w_tx_wdata;
        end
        if (w_rx_we) begin
            r_mem[w_rx_base + w_rx_waddr] <= w_rx_wdata;
        end
    end

    assign w_tx_rdata = r_mem[w_tx_raddr];
    assign w_rx_rdata = r_mem[w_rx_base + w_rx_raddr];

    always_comb begin
        w_status_set                = '0;
        w_status_set[STAT_TX_OVER]  = w_tx_over;
        w_status_set[STAT_TX_UNDER] = w_tx_under;
        w_status_set[STAT_RX_OVER]  = w_rx_over;
        w_status_set[STAT_RX_UNDER] = w_rx_under;
    end

    // Sticky error flags: clear by mask, but a new event in the same cycle wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~status_clr) | w_status_set;
        end
    end

    assign status = r_status;

endmodule : fifo_pair

`default_nettype wire

// File: tb/tb_fifo_pair.sv
// ============================================================================
// Module : tb_fifo_pair
// Brief  : Directed self-checking bench for fifo_pair (WIDTH=32, DEPTH=4).
//          Join-mode scenarios run when FIFO_PAIR_JOIN_EN is defined;
//          otherwise the bench confirms join_mode has no effect.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_pair;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic [1:0]        join_mode;
    logic              tx_write;
    logic [WIDTH-1:0]  tx_wdata;
    logic              tx_pull;
    logic [WIDTH-1:0]  tx_dout;
    logic              tx_empty;
    logic              tx_full;
    logic              rx_push;
    logic [WIDTH-1:0]  rx_din;
    logic              rx_read;
    logic [WIDTH-1:0]  rx_rdata;
    logic              rx_empty;
    logic              rx_full;
    logic [3:0]        tx_level;
    logic [3:0]        rx_level;
    logic [3:0]        status;
    logic [3:0]        status_clr;

    int checks;
    int errors;

    fifo_pair #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .join_mode  (join_mode),
        .tx_write   (tx_write),
        .tx_wdata   (tx_wdata),
        .tx_pull    (tx_pull),
        .tx_dout    (tx_dout),
        .tx_empty   (tx_empty),
        .tx_full    (tx_full),
        .rx_push    (rx_push),
        .rx_din     (rx_din),
        .rx_read    (rx_read),
        .rx_rdata   (rx_rdata),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .tx_level   (tx_level),
        .rx_level   (rx_level),
        .status     (status),
        .status_clr (status_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_wr(input logic [WIDTH-1:0] d);
        tx_write = 1'b1; tx_wdata = d;
        tick();
        tx_write = 1'b0;
    endtask

    task automatic rx_wr(input logic [WIDTH-1:0] d);
        rx_push = 1'b1; rx_din = d;
        tick();
        rx_push = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset_tx_empty: got %b expected 1", tx_empty); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); end
        checks++; if (tx_full !== 1'b0 || rx_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b%b expected 00", tx_full, rx_full); end
        checks++; if (tx_level !== 4'd0 || rx_level !== 4'd0) begin errors++; $display("FAIL reset_levels: got %0d/%0d expected 0/0", tx_level, rx_level); end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL reset_status: got %b expected 0000", status); end
        checks++; if (tx_dout !== 32'h0 || rx_rdata !== 32'h0) begin errors++; $display("FAIL reset_heads: got %h/%h expected 0/0", tx_dout, rx_rdata); end
    endtask

    task automatic test_tx_fill_drain();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < 4; i++) tx_wr(32'hA1 + i);
        checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL tx_full_at_4: got %b expected 1", tx_full); end
        checks++; if (tx_level !== 4'd4) begin errors++; $display("FAIL tx_level_at_4: got %0d expected 4", tx_level); end
        tx_wr(32'hA5);
        checks++; if (tx_level !== 4'd4) begin errors++; $display("FAIL tx_level_after_drop: got %0d expected 4", tx_level); end
        checks++; if (status !== 4'b0001) begin errors++; $display("FAIL tx_over_flag: got %b expected 0001", status); end
        for (int i = 0; i < 4; i++) begin
            exp = 32'hA1 + i;
            checks++; if (tx_dout !== exp) begin errors++; $display("FAIL tx_drain_%0d: got %h expected %h", i, tx_dout, exp); end
            tx_pull = 1'b1; tick(); tx_pull = 1'b0;
        end
        checks++; if (tx_empty !== 1'b1 || tx_dout !== 32'h0) begin errors++; $display("FAIL tx_drained: got empty=%b dout=%h expected 1/0", tx_empty, tx_dout); end
        status_clr = 4'b0001; tick(); status_clr = 4'b0000;
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL tx_over_clear: got %b expected 0000", status); end
        tx_pull = 1'b1; tick(); tx_pull = 1'b0;
        checks++; if (status !== 4'b0010 || tx_level !== 4'd0) begin errors++; $display("FAIL tx_under: got status=%b level=%0d expected 0010/0", status, tx_level); end
        status_clr = 4'b1111; tick(); status_clr = 4'b0000;
    endtask

    task automatic test_back_to_back_full();
        logic [WIDTH-1:0] exp_q [4];
        exp_q[0] = 32'hA2; exp_q[1] = 32'hA3; exp_q[2] = 32'hA4; exp_q[3] = 32'hB5;
        for (int i = 0; i < 4; i++) tx_wr(32'hA1 + i);
        tx_write = 1'b1; tx_wdata = 32'hB5; tx_pull = 1'b1;
        tick();
        tx_write = 1'b0; tx_pull = 1'b0;
        checks++; if (tx_level !== 4'd4 || tx_full !== 1'b1) begin errors++; $display("FAIL full_wr_pop_level: got %0d full=%b expected 4/1", tx_level, tx_full); end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL full_wr_pop_no_over: got %b expected 0000", status); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (tx_dout !== exp_q[i]) begin errors++; $display("FAIL full_wr_pop_drain_%0d: got %h expected %h", i, tx_dout, exp_q[i]); end
            tx_pull = 1'b1; tick(); tx_pull = 1'b0;
        end
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL full_wr_pop_empty: got %b expected 1", tx_empty); end
    endtask

    task automatic test_rx_underflow();
        rx_read = 1'b1; tick(); rx_read = 1'b0;
        checks++; if (status !== 4'b1000) begin errors++; $display("FAIL rx_under_flag: got %b expected 1000", status); end
        checks++; if (rx_rdata !== 32'h0) begin errors++; $display("FAIL rx_rdata_empty: got %h expected 0", rx_rdata); end
        rx_read = 1'b1; status_clr = 4'b1000; tick(); rx_read = 1'b0; status_clr = 4'b0000;
        checks++; if (status !== 4'b1000) begin errors++; $display("FAIL set_wins_over_clr: got %b expected 1000", status); end
        status_clr = 4'b1000; tick(); status_clr = 4'b0000;
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL rx_under_clear: got %b expected 0000", status); end
        rx_push = 1'b1; rx_din = 32'hE1; rx_read = 1'b1;
        tick();
        rx_push = 1'b0; rx_read = 1'b0;
        checks++; if (rx_level !== 4'd1 || rx_rdata !== 32'hE1) begin errors++; $display("FAIL rx_empty_wr_pop: got level=%0d head=%h expected 1/e1", rx_level, rx_rdata); end
        checks++; if (status !== 4'b1000) begin errors++; $display("FAIL rx_empty_wr_pop_under: got %b expected 1000", status); end
        for (int i = 0; i < 4; i++) rx_wr(32'hE2 + i);
        checks++; if (rx_full !== 1'b1 || rx_level !== 4'd4) begin errors++; $display("FAIL rx_full: got full=%b level=%0d expected 1/4", rx_full, rx_level); end
        checks++; if (status !== 4'b1100) begin errors++; $display("FAIL rx_over_flag: got %b expected 1100", status); end
        rx_read = 1'b1; tick(); tick(); rx_read = 1'b0;
        checks++; if (rx_rdata !== 32'hE3 || rx_level !== 4'd2) begin errors++; $display("FAIL rx_pop_order: got head=%h level=%0d expected e3/2", rx_rdata, rx_level); end
        status_clr = 4'b1111; tick(); status_clr = 4'b0000;
        do_reset();
    endtask

`ifdef FIFO_PAIR_JOIN_EN
    task automatic test_join();
        join_mode = 2'b01; tick();
        for (int i = 0; i < 7; i++) tx_wr(32'hD0 + i);
        checks++; if (tx_full !== 1'b0 || tx_level !== 4'd7) begin errors++; $display("FAIL join_tx_7: got full=%b level=%0d expected 0/7", tx_full, tx_level); end
        tx_wr(32'hD7);
        checks++; if (tx_full !== 1'b1 || tx_level !== 4'd8) begin errors++; $display("FAIL join_tx_8: got full=%b level=%0d expected 1/8", tx_full, tx_level); end
        checks++; if (rx_empty !== 1'b1 || rx_full !== 1'b1) begin errors++; $display("FAIL join_tx_rx_flags: got empty=%b full=%b expected 1/1", rx_empty, rx_full); end
        rx_wr(32'hFF);
        checks++; if (status !== 4'b0100 || rx_level !== 4'd0) begin errors++; $display("FAIL join_tx_rx_over: got %b level=%0d expected 0100/0", status, rx_level); end
        checks++; if (tx_dout !== 32'hD0) begin errors++; $display("FAIL join_tx_head: got %h expected d0", tx_dout); end
        join_mode = 2'b00; do_reset();
        for (int i = 0; i < 3; i++) tx_wr(32'hC0 + i);
        checks++; if (tx_level !== 4'd3) begin errors++; $display("FAIL pre_flush_level: got %0d expected 3", tx_level); end
        join_mode = 2'b10; tx_write = 1'b1; tx_wdata = 32'h99; tick(); tx_write = 1'b0;
        checks++; if (tx_level !== 4'd0 || rx_level !== 4'd0 || tx_empty !== 1'b1) begin errors++; $display("FAIL join_flush: got tx=%0d rx=%0d empty=%b expected 0/0/1", tx_level, rx_level, tx_empty); end
        checks++; if (tx_full !== 1'b1 || status !== 4'b0000) begin errors++; $display("FAIL join_rx_tx_flags: got full=%b status=%b expected 1/0000", tx_full, status); end
        for (int i = 0; i < 8; i++) rx_wr(32'hF0 + i);
        checks++; if (rx_full !== 1'b1 || rx_level !== 4'd8 || rx_rdata !== 32'hF0) begin errors++; $display("FAIL join_rx_8: got full=%b level=%0d head=%h expected 1/8/f0", rx_full, rx_level, rx_rdata); end
        join_mode = 2'b00; do_reset();
    endtask
`else
    task automatic test_join_ignored();
        for (int i = 0; i < 3; i++) tx_wr(32'hC0 + i);
        join_mode = 2'b01; tick();
        checks++; if (tx_level !== 4'd3) begin errors++; $display("FAIL join_ignored_level: got %0d expected 3", tx_level); end
        tx_wr(32'hC3);
        checks++; if (tx_full !== 1'b1 || rx_full !== 1'b0) begin errors++; $display("FAIL join_ignored_cap: got tx_full=%b rx_full=%b expected 1/0", tx_full, rx_full); end
        join_mode = 2'b00; do_reset();
    endtask
`endif

    task automatic test_reset_mid_stream();
        rx_read = 1'b1; tick(); rx_read = 1'b0;
        tx_wr(32'h11); tx_wr(32'h12);
        rx_wr(32'h21); rx_wr(32'h22);
        checks++; if (tx_level !== 4'd2 || rx_level !== 4'd2 || status !== 4'b1000) begin errors++; $display("FAIL pre_reset_state: got %0d/%0d status=%b expected 2/2/1000", tx_level, rx_level, status); end
        reset = 1'b1; tx_write = 1'b1; tx_wdata = 32'h13; rx_push = 1'b1; rx_din = 32'h23;
        tick();
        reset = 1'b0; tx_write = 1'b0; rx_push = 1'b0;
        checks++; if (tx_level !== 4'd0 || rx_level !== 4'd0) begin errors++; $display("FAIL mid_reset_levels: got %0d/%0d expected 0/0", tx_level, rx_level); end
        checks++; if (status !== 4'b0000) begin errors++; $display("FAIL mid_reset_status: got %b expected 0000", status); end
        checks++; if (tx_empty !== 1'b1 || rx_empty !== 1'b1) begin errors++; $display("FAIL mid_reset_empty: got %b/%b expected 1/1", tx_empty, rx_empty); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; join_mode = 2'b00;
        tx_write = 1'b0; tx_wdata = '0; tx_pull = 1'b0;
        rx_push = 1'b0; rx_din = '0; rx_read = 1'b0;
        status_clr = 4'b0000;
        #1;
        test_reset();
        test_tx_fill_drain();
        test_back_to_back_full();
        test_rx_underflow();
`ifdef FIFO_PAIR_JOIN_EN
        test_join();
`else
        test_join_ignored();
`endif
        test_reset_mid_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_pair

`default_nettype wire

// File: doc/fifo_pair.md
FIFO_PAIR -- requirements
Module: fifo_pair

Interface
REQ-001 Parameter WIDTH, default 32, data word width.
REQ-002 Parameter DEPTH, default 4, entries per direction when unjoined; power of two.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 Port `clk`  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port `reset`  in  1  synchronous, active-high; overrides all other inputs.
REQ-006 Port `join`  in  2  FIFO join mode: 00 none, 01 all to TX, 10 all to RX, 11 treated as 00.
REQ-007 Port `tx_write`  in  1  host push into TX FIFO.
REQ-008 Port `tx_wdata`  in  WIDTH  host TX data.
REQ-009 Port `tx_pull`  in  1  machine pops the TX head.
REQ-010 Port `tx_dout`  out  WIDTH  TX head word, first-word-fall-through, to machine din.
REQ-011 Port `tx_empty`  out  1  TX holds no words.
REQ-012 Port `tx_full`  out  1  TX at capacity.
REQ-013 Port `rx_push`  in  1  machine push into RX FIFO.
REQ-014 Port `rx_din`  in  WIDTH  machine dout.
REQ-015 Port `rx_read`  in  1  host pops the RX head.
REQ-016 Port `rx_rdata`  out  WIDTH  RX head word, first-word-fall-through.
REQ-017 Port `rx_empty`  out  1  RX holds no words.
REQ-018 Port `rx_full`  out  1  RX at capacity.
REQ-019 Port `tx_level`  out  log2(2*DEPTH)+1  TX occupancy.
REQ-020 Port `rx_level`  out  log2(2*DEPTH)+1  RX occupancy.
REQ-021 Port `status`  out  4  sticky flags: {rx_under, rx_over, tx_under, tx_over}.
REQ-022 Port `status_clr`  in  4  write-one-to-clear mask for `status`.

Function
REQ-023 Capacity: TX is 2*DEPTH with join=01, 0 with join=10, otherwise DEPTH; RX is symmetric.
REQ-024 A capacity-0 FIFO SHALL hold `empty`=1 and `full`=1 permanently.
REQ-025 A write while not full SHALL store the data and raise level by 1 on the next edge.
REQ-026 A pop while not empty SHALL advance the head and lower level by 1 on the next edge.
REQ-027 `tx_dout` and `rx_rdata` SHALL show the head word combinationally; they SHALL be 0 when empty.
REQ-028 Simultaneous write and pop while non-empty, including full, SHALL both take effect with level unchanged.
REQ-029 Simultaneous write and pop while empty: the write is stored, the pop is an underflow, level becomes 1.
REQ-030 A write while full SHALL be dropped and set the matching `_over` flag; stored contents are unchanged.
REQ-031 A pop while empty SHALL set the matching `_under` flag; pointers are unchanged.
REQ-032 Read and write pointers SHALL wrap modulo the current capacity.
REQ-033 `full` and `empty` SHALL be registered-state derived: level==capacity and level==0.
REQ-034 A change of `join` SHALL flush both FIFOs (levels 0, pointers 0) on the edge it is sampled; writes and pops that cycle are ignored.
REQ-035 A `status` bit SHALL clear when its `status_clr` bit is 1, unless the same bit is set in the same cycle, in which case set wins.

Reset
REQ-036 On reset: levels 0, pointers 0, `status`=0, `tx_empty`=`rx_empty`=1; full flags follow REQ-024; stored data is don't-care.
REQ-037 A reset asserted mid-transfer SHALL discard all contents in that cycle.

Configuration
REQ-038 Macro FIFO_PAIR_JOIN_EN: when defined, join modes operate as specified in REQ-006, REQ-023 and REQ-034.
REQ-039 When FIFO_PAIR_JOIN_EN is undefined, `join` SHALL be ignored, capacities SHALL be fixed at DEPTH, and storage SHALL be 2*DEPTH words total.

Structure
REQ-040 Package pio_pkg SHALL hold the join-mode constants JOIN_NONE, JOIN_TX and JOIN_RX, and the status bit indices.
REQ-041 A single sub-module `sync_fifo` (WIDTH, max depth, runtime capacity input) SHALL be instantiated twice.
REQ-042 When joining is enabled, the two `sync_fifo` instances SHALL share a 2*DEPTH storage split by `join`.

Verification
REQ-043 Reset, join=00: write 0xA1..0xA4 to TX -> `tx_full`=1, `tx_level`=4; 5th write dropped and tx_over=1; pops return 0xA1..0xA4 in order.
REQ-044 TX full, simultaneous write 0xB5 and pull -> `tx_level` stays 4; drain order is A2, A3, A4, B5.
REQ-045 join=01: 8 writes accepted, `tx_full`=1 only after the 8th; `rx_empty`=`rx_full`=1; `rx_push` sets rx_over.
REQ-046 RX empty, `rx_read` -> rx_under=1, `rx_rdata`=0; `status_clr`=4'b1000 in the same cycle as a new underflow -> flag stays 1.
REQ-047 TX level 3, join changes 00->10 -> next cycle both levels 0, `tx_empty`=1; RX accepts 8 words.
REQ-048 Reset asserted mid-stream with both FIFOs half full -> next cycle levels 0, `status`=0, empty flags 1.
